// File: rtl/psa_pkg.sv
// psa_pkg: shared defaults and elaboration helpers for pipelined_segment_adder.
package psa_pkg;

  localparam int PSA_WIDTH_DEF     = 32;
  localparam int PSA_SEG_WIDTH_DEF = 8;

  function automatic int nseg(input int width, input int seg_width);
    return width / seg_width;
  endfunction

  // Only whole, non-empty segments are supported.
  function automatic bit seg_cfg_ok(input int width, input int seg_width);
    return (seg_width > 0) && (width >= seg_width) && ((width % seg_width) == 0);
  endfunction

endpackage

// File: rtl/psa_segment.sv
// psa_segment: combinational SEG_WIDTH-bit ripple adder built from full-adder cells.
module psa_segment #(
  parameter int SEG_WIDTH = 8
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [SEG_WIDTH-1:0] sum,
  output logic                 cout
);

  logic carry;

  // Carry is kept in a single variable walked bit by bit so the chain stays one combinational process.
  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < SEG_WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_segment_adder.sv
// pipelined_segment_adder: WIDTH-bit a+b+cin, one SEG_WIDTH-bit ripple segment per pipeline stage.
// Define PSA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_segment_adder
  import psa_pkg::*;
#(
  parameter int WIDTH     = PSA_WIDTH_DEF,
  parameter int SEG_WIDTH = PSA_SEG_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = nseg(WIDTH, SEG_WIDTH);

  typedef logic [SEG_WIDTH-1:0] seg_t;
  typedef logic [NSEG-1:0]      stage_vld_t;

  if (!seg_cfg_ok(WIDTH, SEG_WIDTH)) begin : g_cfg_err
    $error("pipelined_segment_adder: WIDTH must be a non-zero multiple of SEG_WIDTH");
  end

  stage_vld_t vld_q;
  stage_vld_t carry_q;
  stage_vld_t seg_cout;
  logic       adv;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv       = !vld_q[NSEG-1] || out_ready;
  assign in_ready  = adv && !rst;
  assign out_valid = vld_q[NSEG-1];
  assign cout      = carry_q[NSEG-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      carry_q <= '0;
    end else if (adv) begin
      vld_q   <= stage_vld_t'({vld_q, in_valid});
      carry_q <= seg_cout;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // REM: operand bits still to be added entering this stage; DONE: sum bits complete after it.
    localparam int REM  = WIDTH - k * SEG_WIDTH;
    localparam int DONE = (k + 1) * SEG_WIDTH;

    logic [REM-1:0]  op_a;
    logic [REM-1:0]  op_b;
    logic            seg_cin;
    seg_t            seg_s;
    logic [DONE-1:0] sum_q;

    if (k == 0) begin : g_head
      assign op_a    = a;
      assign op_b    = b;
      assign seg_cin = cin;
    end else begin : g_link
      assign op_a    = g_stage[k-1].g_ops.a_q;
      assign op_b    = g_stage[k-1].g_ops.b_q;
      assign seg_cin = carry_q[k-1];
    end

    psa_segment #(
      .SEG_WIDTH(SEG_WIDTH)
    ) u_seg (
      .a   (op_a[SEG_WIDTH-1:0]),
      .b   (op_b[SEG_WIDTH-1:0]),
      .cin (seg_cin),
      .sum (seg_s),
      .cout(seg_cout[k])
    );

    // Upper operand segments ride along skewed until their own stage consumes them.
    if (k < NSEG - 1) begin : g_ops
      logic [REM-SEG_WIDTH-1:0] a_q;
      logic [REM-SEG_WIDTH-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= op_a[REM-1:SEG_WIDTH];
          b_q <= op_b[REM-1:SEG_WIDTH];
        end
      end
    end

    if (k == 0) begin : g_sum_head
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q <= '0;
        end else if (adv) begin
          sum_q <= seg_s;
        end
      end
    end else begin : g_sum_link
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q <= '0;
        end else if (adv) begin
          sum_q <= {seg_s, g_stage[k-1].sum_q};
        end
      end
    end

    if (k == NSEG - 1) begin : g_tail
      assign sum = sum_q;

`ifdef PSA_OVERFLOW_EN
      // Same-sign operands whose result sign flips; registered alongside the top segment.
      logic ovf_d;

      assign ovf_d = (op_a[SEG_WIDTH-1] == op_b[SEG_WIDTH-1]) &&
                     (seg_s[SEG_WIDTH-1] != op_a[SEG_WIDTH-1]);

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf <= 1'b0;
        end else if (adv) begin
          ovf <= ovf_d;
        end
      end
`endif
    end
  end

endmodule
